// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: 2-flop sync + glitch filter per phase, x4 position
// counter with illegal-transition flag, and windowed saturating speed measurement.
module quad_decoder #(
    parameter int WIDTH  = 32,
    parameter int SWIDTH = 16,
    parameter int FILTER = 2,
    parameter int PERIOD = 50000
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    input  logic              A,
    input  logic              B,
    input  logic              CLEAR,
    input  logic              ERR_CLR,
    output logic [WIDTH-1:0]  POSITION,
    output logic              STEP,
    output logic              DIR,
    output logic [SWIDTH-1:0] SPEED,
    output logic              SPEED_VALID,
    output logic              ERROR
);

    localparam int                WW   = $clog2(PERIOD);
    localparam logic [3:0]        FMAX = 4'(FILTER - 1);
    localparam logic [SWIDTH-1:0] SMAX = {1'b0, {(SWIDTH-1){1'b1}}};
    localparam logic [SWIDTH-1:0] SNEG = SWIDTH'(0) - SMAX;

    typedef enum logic {ST_WAIT, ST_RUN} state_t;

    state_t            r_state, w_state_next;
    logic              r_wait_cnt, w_wait_cnt_next;
    logic              w_run;

    logic [1:0]        r_s1, r_s2, r_acc, r_prev;
    logic [1:0][3:0]   r_cnt;

    logic              w_fwd, w_rev, w_ill;

    logic [WIDTH-1:0]  r_position;
    logic              r_step, r_dir, r_error;
    logic [SWIDTH-1:0] r_speed, r_accum, w_accum_next;
    logic              r_speed_valid;
    logic [WW-1:0]     r_win;
    logic              w_win_end;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_run           = 1'b0;
        case (r_state)
            ST_WAIT: begin
                w_wait_cnt_next = 1'b1;
                if (r_wait_cnt) w_state_next = ST_RUN;
            end
            ST_RUN:  w_run = 1'b1;
            default: w_state_next = ST_WAIT;
        endcase
    end

    // Index 0 is phase A, index 1 is phase B; both filters run independently.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_acc  <= '0;
            r_prev <= '0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= {B, A};
            r_s2   <= r_s1;
            r_prev <= r_acc;
            for (int unsigned i = 0; i < 2; i++) begin
                if (!w_run) begin
                    r_acc[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else if (r_s2[i] == r_acc[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == FMAX) begin
                    r_acc[i] <= r_s2[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_fwd = 1'b0;
        w_rev = 1'b0;
        w_ill = 1'b0;
        if (w_run) begin
            case ({r_prev, r_acc})
                4'b01_11, 4'b11_10, 4'b10_00, 4'b00_01: w_fwd = 1'b1;
                4'b11_01, 4'b10_11, 4'b00_10, 4'b01_00: w_rev = 1'b1;
                4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_ill = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_accum_next = r_accum;
        if (w_fwd && r_accum != SMAX) w_accum_next = r_accum + SWIDTH'(1);
        if (w_rev && r_accum != SNEG) w_accum_next = r_accum - SWIDTH'(1);
    end

    assign w_win_end = (r_win == WW'(PERIOD - 1));

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_position    <= '0;
            r_step        <= 1'b0;
            r_dir         <= 1'b0;
            r_error       <= 1'b0;
            r_speed       <= '0;
            r_speed_valid <= 1'b0;
            r_accum       <= '0;
            r_win         <= '0;
        end else begin
            if (CLEAR)      r_position <= '0;
            else if (w_fwd) r_position <= r_position + WIDTH'(1);
            else if (w_rev) r_position <= r_position - WIDTH'(1);

            r_step <= w_fwd | w_rev;
            if (w_fwd)      r_dir <= 1'b1;
            else if (w_rev) r_dir <= 1'b0;

            if (w_ill)        r_error <= 1'b1;
            else if (ERR_CLR) r_error <= 1'b0;

            // The closing cycle's step is folded into the published value, not the next window.
            if (w_win_end) begin
                r_speed       <= w_accum_next;
                r_speed_valid <= 1'b1;
                r_accum       <= '0;
                r_win         <= '0;
            end else begin
                r_speed_valid <= 1'b0;
                r_accum       <= w_accum_next;
                r_win         <= r_win + WW'(1);
            end
        end
    end

    assign POSITION    = r_position;
    assign STEP        = r_step;
    assign DIR         = r_dir;
    assign SPEED       = r_speed;
    assign SPEED_VALID = r_speed_valid;
    assign ERROR       = r_error;

endmodule

// File: tb/tb_quad_decoder.sv
// Bench for quad_decoder: two instances (32/16-bit and 8/4-bit) share one stimulus
// and are compared every cycle against a sample-history model, plus literal pins.
module tb_quad_decoder;

    localparam int F = 2;
    localparam int P = 100;

    logic CLOCK = 1'b0;
    logic RESET_N = 1'b1;
    logic a = 1'b0, b = 1'b0, clear = 1'b0, err_clr = 1'b0;

    logic [31:0] pos32;
    logic [7:0]  pos8;
    logic [15:0] spd32;
    logic [3:0]  spd4;
    logic step32, step8, dir32, dir8, sv32, sv8, err32, err8;

    always #5 CLOCK = ~CLOCK;

    quad_decoder #(.WIDTH(32), .SWIDTH(16), .FILTER(F), .PERIOD(P)) u_dut32 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .A(a), .B(b), .CLEAR(clear), .ERR_CLR(err_clr),
        .POSITION(pos32), .STEP(step32), .DIR(dir32), .SPEED(spd32),
        .SPEED_VALID(sv32), .ERROR(err32));

    quad_decoder #(.WIDTH(8), .SWIDTH(4), .FILTER(F), .PERIOD(P)) u_dut8 (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .A(a), .B(b), .CLEAR(clear), .ERR_CLR(err_clr),
        .POSITION(pos8), .STEP(step8), .DIR(dir8), .SPEED(spd4),
        .SPEED_VALID(sv8), .ERROR(err8));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [1:0]  rh [0:7];
    logic [1:0]  m_acc1, m_acc2, md_nacc;
    longint      m_pos;
    logic        m_step, m_dir, m_err, m_sv;
    int          m_acc16, m_acc4, m_spd16, m_spd4, md_d;
    int unsigned m_n;
    bit          md_ill, md_flip;

    function automatic int qidx(input logic [1:0] ba);
        case (ba)
            2'b01:   return 0;
            2'b11:   return 1;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int sat(input int v, input int m);
        if (v > m) return m;
        if (v < -m) return -m;
        return v;
    endfunction

    always @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int j = 0; j < 8; j++) rh[j] = 2'b00;
            m_acc1 = 2'b00; m_acc2 = 2'b00; m_pos = 0;
            m_step = 0; m_dir = 0; m_err = 0; m_sv = 0;
            m_acc16 = 0; m_acc4 = 0; m_spd16 = 0; m_spd4 = 0; m_n = 0;
        end else begin
            m_n++;
            for (int j = 7; j > 0; j--) rh[j] = rh[j-1];
            rh[0] = {b, a};
            md_d = 0;
            md_ill = 0;
            if (m_n >= 3 && m_acc1 != m_acc2) begin
                case ((qidx(m_acc1) - qidx(m_acc2) + 4) % 4)
                    1:       md_d = 1;
                    3:       md_d = -1;
                    default: md_ill = 1;
                endcase
            end
            if (md_ill) m_err = 1;
            else if (err_clr) m_err = 0;
            if (clear) m_pos = 0;
            else m_pos = m_pos + md_d;
            m_step = (md_d != 0);
            if (md_d != 0) m_dir = (md_d > 0);
            m_acc16 = sat(m_acc16 + md_d, 32767);
            m_acc4  = sat(m_acc4 + md_d, 7);
            m_sv = (m_n % P == 0);
            if (m_sv) begin
                m_spd16 = m_acc16; m_spd4 = m_acc4;
                m_acc16 = 0; m_acc4 = 0;
            end
            // A level is accepted once the synced samples have disagreed with it F times running.
            md_nacc = m_acc1;
            if (m_n <= 2) md_nacc = rh[2];
            else begin
                for (int i = 0; i < 2; i++) begin
                    md_flip = 1;
                    for (int j = 2; j <= 1 + F; j++)
                        if (rh[j][i] == m_acc1[i]) md_flip = 0;
                    if (md_flip) md_nacc[i] = ~m_acc1[i];
                end
            end
            m_acc2 = m_acc1;
            m_acc1 = md_nacc;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 0;
    int          step_cnt = 0;
    logic [15:0] last_spd32 = '0;
    logic [3:0]  last_spd4 = '0;
    logic [15:0] e16;
    logic [3:0]  e4;

    always @(negedge CLOCK) begin
        if (chk_en) begin
            e16 = m_spd16[15:0];
            e4  = m_spd4[3:0];
            chk("pos32", pos32, m_pos[31:0]);
            chk("pos8", pos8, m_pos[7:0]);
            chk("step32", step32, m_step);
            chk("step8", step8, m_step);
            chk("dir32", dir32, m_dir);
            chk("dir8", dir8, m_dir);
            chk("err32", err32, m_err);
            chk("err8", err8, m_err);
            chk("sv32", sv32, m_sv);
            chk("sv8", sv8, m_sv);
            chk("spd32", spd32, e16);
            chk("spd4", spd4, e4);
            if (step32) step_cnt++;
            if (sv32) last_spd32 = spd32;
            if (sv8) last_spd4 = spd4;
        end
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic [1:0] ba, input int hold, input int clr_at,
                         input int eclr_at, output int step_at);
        {b, a} = ba;
        step_at = 0;
        for (int i = 1; i <= hold; i++) begin
            clear   = (i == clr_at);
            err_clr = (i == eclr_at);
            @(posedge CLOCK); #1;
            if (step32 && step_at == 0) step_at = i;
        end
        clear = 1'b0;
        err_clr = 1'b0;
    endtask

    logic [1:0] fseq [0:3];
    logic [1:0] rseq [0:3];
    int sa, sc0, lat;

    initial begin
        fseq[0] = 2'b01; fseq[1] = 2'b11; fseq[2] = 2'b10; fseq[3] = 2'b00;
        rseq[0] = 2'b10; rseq[1] = 2'b11; rseq[2] = 2'b01; rseq[3] = 2'b00;

        #2 RESET_N = 1'b0;
        chk_en = 1;
        repeat (3) @(posedge CLOCK);
        #1;
        chk("rst_pos", pos32, 0);
        chk("rst_step", step32, 0);
        chk("rst_sv", sv32, 0);
        chk("rst_err", err32, 0);
        RESET_N = 1'b1;
        repeat (5) @(posedge CLOCK);
        #1;

        // forward x2
        sc0 = step_cnt;
        for (int s = 0; s < 8; s++) begin
            apply(fseq[s % 4], 10, 0, 0, sa);
            if (s == 0) chk("fwd_latency", sa, 5);
        end
        chk("fwd_pos", pos32, 8);
        chk("fwd_steps", step_cnt - sc0, 8);
        chk("fwd_dir", dir32, 1);
        chk("fwd_err", err32, 0);

        // reverse x3
        for (int s = 0; s < 12; s++) apply(rseq[s % 4], 10, 0, 0, sa);
        chk("rev_pos", pos32, 64'h0000_0000_FFFF_FFFC);
        chk("rev_dir", dir32, 0);

        // glitches
        sc0 = step_cnt;
        apply(2'b01, 1, 0, 0, sa);
        apply(2'b00, 10, 0, 0, sa);
        chk("glitch1_steps", step_cnt - sc0, 0);
        chk("glitch1_pos", pos32, 64'h0000_0000_FFFF_FFFC);
        sc0 = step_cnt;
        apply(2'b01, 3, 0, 0, sa);
        apply(2'b00, 10, 0, 0, sa);
        chk("glitch3_steps", step_cnt - sc0, 2);
        chk("glitch3_pos", pos32, 64'h0000_0000_FFFF_FFFC);

        // illegal transitions and ERR_CLR priority
        apply(2'b11, 10, 0, 0, sa);
        chk("ill_err", err32, 1);
        chk("ill_pos", pos32, 64'h0000_0000_FFFF_FFFC);
        apply(2'b00, 10, 0, 5, sa);
        chk("ill_setwins", err32, 1);
        apply(2'b00, 3, 0, 1, sa);
        chk("errclr", err32, 0);

        // mid-operation reset clears immediately
        @(posedge CLOCK); #3;
        RESET_N = 1'b0;
        #1;
        chk("midrst_pos", pos32, 0);
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        lat = 0;
        for (int i = 1; i <= 200 && lat == 0; i++) begin
            @(posedge CLOCK); #1;
            if (sv32) lat = i;
        end
        chk("first_sv_edge", lat, P);

        // 128 forward steps every 5 cycles: wrap at WIDTH=8, saturate SWIDTH=4
        for (int s = 0; s < 127; s++) apply(fseq[s % 4], 5, 0, 0, sa);
        chk("pre_wrap32", pos32, 127);
        chk("pre_wrap8", pos8, 8'h7F);
        apply(fseq[127 % 4], 5, 0, 0, sa);
        chk("wrap8", pos8, 8'h80);
        chk("wrap32", pos32, 128);
        chk("speed20", last_spd32, 20);
        chk("speed_sat", last_spd4, 7);

        // CLEAR coincident with a step
        apply(2'b01, 10, 5, 0, sa);
        chk("clr_step_at", sa, 5);
        chk("clr_pos", pos32, 0);

        // steps every 10 cycles
        for (int s = 1; s <= 40; s++) apply(fseq[s % 4], 10, 0, 0, sa);
        chk("speed10", last_spd32, 10);
        chk("speed10_sat", last_spd4, 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "timeout");
    end

endmodule
